// File: rtl/brick_field.sv
// Brick wall state plus per-pixel solid/collision decode for the ball, walls and paddle.
// Pixel outputs register one cycle after pix_*; no backpressure, one pixel accepted every cycle.
module brick_field #(
    parameter int BRICK_COLS   = 8,
    parameter int BRICK_ROWS   = 6,
    parameter int BRICK_W      = 78,
    parameter int BRICK_H      = 16,
    parameter int BRICK_LEFT   = 8,
    parameter int BRICK_TOP    = 48,
    parameter int BORDER_WIDTH = 8,
    parameter int BALL_SIZE    = 4,
    parameter int PADDLE_WIDTH = 99,
    parameter int PADDLE_Y     = 456,
    parameter int PADDLE_H     = 8
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic [9:0] pix_x,
    input  logic [8:0] pix_y,
    input  logic       pix_valid,
    input  logic       frame_pulse,
    input  logic       new_game,
    input  logic [9:0] ball_x,
    input  logic [8:0] ball_y,
    input  logic [9:0] paddle_x,
    output logic       brick_pixel,
    output logic [2:0] brick_row,
    output logic       collision,
    output logic       ball_top_col,
    output logic       ball_bottom_col,
    output logic       ball_left_col,
    output logic       ball_right_col,
    output logic [7:0] score,
    output logic [5:0] bricks_left,
    output logic       all_cleared
);

    localparam int NUM_BRICKS = BRICK_ROWS * BRICK_COLS;
    localparam int SCREEN_W   = 640;

    logic [NUM_BRICKS-1:0] alive_q, alive_d;
    logic [5:0]            bricks_left_q, bricks_left_d;
    logic [7:0]            score_q, score_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [5:0]            pend_idx_q, pend_idx_d;

    logic       brick_pixel_q, brick_pixel_d;
    logic [2:0] brick_row_q, brick_row_d;
    logic       collision_q, collision_d;
    logic       top_q, top_d, bottom_q, bottom_d, left_q, left_d, right_q, right_d;

    logic [10:0] x_w, px_w, bx_w;
    logic [9:0]  y_w, by_w;
    logic        col_hit, row_hit;
    logic [2:0]  col_idx, row_idx;
    logic [5:0]  brick_idx;
    logic        brick_live, border, paddle, in_ball, pix_live, collide, brick_hit;

    assign x_w  = {1'b0, pix_x};
    assign y_w  = {1'b0, pix_y};
    assign px_w = {1'b0, paddle_x};
    assign bx_w = {1'b0, ball_x};
    assign by_w = {1'b0, ball_y};

    // Cell edges are stepped out from the field origin one cell width at a time;
    // the last pixel column/row of each cell is the mortar gap and never matches.
    always_comb begin
        col_hit = 1'b0;
        col_idx = '0;
        for (int c = 0; c < BRICK_COLS; c++) begin
            if (x_w >= 11'(BRICK_LEFT + c * BRICK_W) &&
                x_w <= 11'(BRICK_LEFT + (c + 1) * BRICK_W - 2)) begin
                col_hit = 1'b1;
                col_idx = 3'(c);
            end
        end
        row_hit = 1'b0;
        row_idx = '0;
        for (int r = 0; r < BRICK_ROWS; r++) begin
            if (y_w >= 10'(BRICK_TOP + r * BRICK_H) &&
                y_w <= 10'(BRICK_TOP + (r + 1) * BRICK_H - 2)) begin
                row_hit = 1'b1;
                row_idx = 3'(r);
            end
        end
    end

    assign brick_idx  = 6'(row_idx) * 6'(BRICK_COLS) + 6'(col_idx);
    assign brick_live = col_hit & row_hit & alive_q[brick_idx];
    assign border     = (x_w < 11'(BORDER_WIDTH)) ||
                        (x_w >= 11'(SCREEN_W - BORDER_WIDTH)) ||
                        (y_w < 10'(BORDER_WIDTH));
    assign paddle     = (x_w >= px_w) && (x_w <= px_w + 11'(PADDLE_WIDTH - 1)) &&
                        (y_w >= 10'(PADDLE_Y)) && (y_w <= 10'(PADDLE_Y + PADDLE_H - 1));
    assign in_ball    = (x_w >= bx_w) && (x_w <= bx_w + 11'(BALL_SIZE - 1)) &&
                        (y_w >= by_w) && (y_w <= by_w + 10'(BALL_SIZE - 1));

    // The frame boundary cycle blanks the pixel path so no hit straddles two frames.
    assign pix_live  = pix_valid & ~frame_pulse;
    assign collide   = pix_live & (brick_live | border | paddle) & in_ball;
    assign brick_hit = pix_live & brick_live & in_ball;

    always_comb begin
        brick_pixel_d = pix_live & brick_live;
        brick_row_d   = brick_pixel_d ? row_idx : 3'd0;
        collision_d   = collide;
        top_d         = collide & (y_w == by_w);
        bottom_d      = collide & (y_w == by_w + 10'(BALL_SIZE - 1));
        left_d        = collide & (x_w == bx_w);
        right_d       = collide & (x_w == bx_w + 11'(BALL_SIZE - 1));
    end

    always_comb begin
        alive_d       = alive_q;
        bricks_left_d = bricks_left_q;
        score_d       = score_q;
        pend_vld_d    = pend_vld_q;
        pend_idx_d    = pend_idx_q;
        if (new_game) begin
            alive_d       = '1;
            bricks_left_d = 6'(NUM_BRICKS);
            score_d       = '0;
            pend_vld_d    = 1'b0;
        end else if (frame_pulse) begin
            // A hit on a brick that is already gone is discarded without scoring.
            if (pend_vld_q && alive_q[pend_idx_q]) begin
                alive_d[pend_idx_q] = 1'b0;
                bricks_left_d       = bricks_left_q - 6'd1;
                score_d             = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            end
            pend_vld_d = 1'b0;
        end else if (brick_hit && !pend_vld_q) begin
            pend_vld_d = 1'b1;
            pend_idx_d = brick_idx;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            alive_q       <= '1;
            bricks_left_q <= 6'(NUM_BRICKS);
            score_q       <= '0;
            pend_vld_q    <= 1'b0;
            pend_idx_q    <= '0;
            brick_pixel_q <= 1'b0;
            brick_row_q   <= '0;
            collision_q   <= 1'b0;
            top_q         <= 1'b0;
            bottom_q      <= 1'b0;
            left_q        <= 1'b0;
            right_q       <= 1'b0;
        end else begin
            alive_q       <= alive_d;
            bricks_left_q <= bricks_left_d;
            score_q       <= score_d;
            pend_vld_q    <= pend_vld_d;
            pend_idx_q    <= pend_idx_d;
            brick_pixel_q <= brick_pixel_d;
            brick_row_q   <= brick_row_d;
            collision_q   <= collision_d;
            top_q         <= top_d;
            bottom_q      <= bottom_d;
            left_q        <= left_d;
            right_q       <= right_d;
        end
    end

    assign brick_pixel     = brick_pixel_q;
    assign brick_row       = brick_row_q;
    assign collision       = collision_q;
    assign ball_top_col    = top_q;
    assign ball_bottom_col = bottom_q;
    assign ball_left_col   = left_q;
    assign ball_right_col  = right_q;
    assign score           = score_q;
    assign bricks_left     = bricks_left_q;
    assign all_cleared     = (bricks_left_q == 6'd0);

endmodule

// File: tb/tb_brick_field.sv
// Randomised and directed bench for brick_field against a division-based reference model.
module tb_brick_field;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic [9:0] pix_x = '0;
    logic [8:0] pix_y = '0;
    logic       pix_valid = 1'b0;
    logic       frame_pulse = 1'b0;
    logic       new_game = 1'b0;
    logic [9:0] ball_x = 10'd300;
    logic [8:0] ball_y = 9'd300;
    logic [9:0] paddle_x = 10'd270;
    logic       brick_pixel, collision, all_cleared;
    logic       ball_top_col, ball_bottom_col, ball_left_col, ball_right_col;
    logic [2:0] brick_row;
    logic [7:0] score;
    logic [5:0] bricks_left;

    always #5 clk = ~clk;

    brick_field dut (
        .clk(clk), .nRst(nRst), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .frame_pulse(frame_pulse), .new_game(new_game), .ball_x(ball_x), .ball_y(ball_y),
        .paddle_x(paddle_x), .brick_pixel(brick_pixel), .brick_row(brick_row),
        .collision(collision), .ball_top_col(ball_top_col), .ball_bottom_col(ball_bottom_col),
        .ball_left_col(ball_left_col), .ball_right_col(ball_right_col), .score(score),
        .bricks_left(bricks_left), .all_cleared(all_cleared)
    );

    // Reference model: wall state plus the outputs expected after the latest edge.
    bit alive_m [48];
    int left_m, score_m, pidx_m;
    bit pend_m;
    int e_bp, e_row, e_col, e_top, e_bot, e_lft, e_rgt;

    always begin
        @(posedge clk or negedge nRst);
        if (!nRst) begin
            foreach (alive_m[i]) alive_m[i] = 1'b1;
            left_m = 48; score_m = 0; pend_m = 0; pidx_m = 0;
            {e_bp, e_row, e_col, e_top, e_bot, e_lft, e_rgt} = '0;
        end else begin
            int x, y, bx, by, px, r, c;
            bit bk, solid, inb, vld, col;
            x = int'(pix_x); y = int'(pix_y); bx = int'(ball_x); by = int'(ball_y);
            px = int'(paddle_x); r = 0; c = 0; bk = 0;
            if (x >= 8 && x < 8 + 8 * 78 && y >= 48 && y < 48 + 6 * 16) begin
                c = (x - 8) / 78;
                r = (y - 48) / 16;
                bk = ((x - 8) % 78 != 77) && ((y - 48) % 16 != 15) && alive_m[r * 8 + c];
            end
            solid = bk || x < 8 || x >= 632 || y < 8 ||
                    (x >= px && x <= px + 98 && y >= 456 && y <= 463);
            inb = x >= bx && x <= bx + 3 && y >= by && y <= by + 3;
            vld = pix_valid && !frame_pulse;
            col = vld && solid && inb;
            e_bp  = int'(vld && bk);
            e_row = e_bp != 0 ? r : 0;
            e_col = int'(col);
            e_top = int'(col && y == by);
            e_bot = int'(col && y == by + 3);
            e_lft = int'(col && x == bx);
            e_rgt = int'(col && x == bx + 3);
            if (new_game) begin
                foreach (alive_m[i]) alive_m[i] = 1'b1;
                left_m = 48; score_m = 0; pend_m = 0;
            end else if (frame_pulse) begin
                if (pend_m && alive_m[pidx_m]) begin
                    alive_m[pidx_m] = 1'b0;
                    left_m  = left_m - 1;
                    score_m = score_m < 255 ? score_m + 1 : 255;
                end
                pend_m = 0;
            end else if (vld && bk && inb && !pend_m) begin
                pend_m = 1; pidx_m = r * 8 + c;
            end
        end
    end

    typedef struct { string name; int sel; int exp; } lit_t;
    lit_t lit_q[$];
    int n_pass = 0, n_total = 0;

    function automatic int dut_val(input int sel);
        case (sel)
            0: return int'(brick_pixel);
            1: return int'(brick_row);
            2: return int'(collision);
            3: return int'(ball_top_col);
            4: return int'(ball_bottom_col);
            5: return int'(ball_left_col);
            6: return int'(ball_right_col);
            7: return int'(score);
            8: return int'(bricks_left);
            default: return int'(all_cleared);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Single compare process: model check every cycle, then any queued literal pins.
    always begin
        @(negedge clk);
        chk("brick_pixel", int'(brick_pixel), e_bp);
        chk("brick_row", int'(brick_row), e_row);
        chk("collision", int'(collision), e_col);
        chk("top", int'(ball_top_col), e_top);
        chk("bottom", int'(ball_bottom_col), e_bot);
        chk("left", int'(ball_left_col), e_lft);
        chk("right", int'(ball_right_col), e_rgt);
        chk("score", int'(score), score_m);
        chk("bricks_left", int'(bricks_left), left_m);
        chk("all_cleared", int'(all_cleared), int'(left_m == 0));
        while (lit_q.size() > 0) begin
            lit_t l;
            l = lit_q.pop_front();
            chk(l.name, dut_val(l.sel), l.exp);
        end
    end

    task automatic lit(input string n, input int sel, input int e);
        lit_t l;
        l.name = n; l.sel = sel; l.exp = e;
        lit_q.push_back(l);
    endtask

    task automatic pix(input int x, input int y, input bit v = 1'b1);
        pix_x = 10'(x); pix_y = 9'(y); pix_valid = v;
        @(posedge clk); #2;
        pix_valid = 1'b0;
    endtask

    task automatic frame();
        frame_pulse = 1'b1;
        @(posedge clk); #2;
        frame_pulse = 1'b0;
    endtask

    task automatic ng(input bit with_fp = 1'b0);
        new_game = 1'b1; frame_pulse = with_fp;
        @(posedge clk); #2;
        new_game = 1'b0; frame_pulse = 1'b0;
    endtask

    task automatic place(input int bx, input int by);
        ball_x = 10'(bx); ball_y = 9'(by);
    endtask

    task automatic hit_brick(input int r, input int c);
        place(8 + c * 78, 48 + r * 16);
        pix(8 + c * 78, 48 + r * 16);
        frame();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 nRst = 1'b1;
        lit("rst_left", 8, 48); lit("rst_score", 7, 0); lit("rst_clr", 9, 0); lit("rst_bp", 0, 0);

        // Ball parked in empty space: nothing should collide.
        place(300, 300); paddle_x = 10'd270;
        pix(8, 48);  lit("bp_8_48", 0, 1); lit("row_8_48", 1, 0);
        pix(85, 48); lit("bp_gapx", 0, 0);
        pix(8, 63);  lit("bp_gapy", 0, 0);
        pix(301, 301); lit("no_col_ball", 2, 0);
        for (int i = 0; i < 300; i++) pix($urandom_range(0, 639), $urandom_range(0, 479));
        frame(); lit("left48", 8, 48);

        place(40, 62);
        pix(40, 62); lit("c40_col", 2, 1); lit("c40_top", 3, 1); lit("c40_left", 5, 1); lit("c40_bot", 4, 0);
        pix(40, 63); lit("c40_gap", 2, 0);
        frame(); lit("c40_score", 7, 1); lit("c40_left47", 8, 47);
        pix(8, 48); lit("dead_00", 0, 0);

        // Two bricks under the ball in one frame: only the first scanned one goes.
        ng();
        place(84, 60);
        for (int y = 60; y < 64; y++) for (int x = 84; x < 88; x++) pix(x, y);
        frame(); lit("two_score", 7, 1); lit("two_left", 8, 47);
        pix(86, 48); lit("b01_alive", 0, 1);

        place(2, 200);
        pix(2, 200); lit("wall_col", 2, 1); lit("wall_left", 5, 1);
        for (int y = 200; y < 204; y++) for (int x = 2; x < 6; x++) pix(x, y);
        frame(); lit("wall_score", 7, 1);
        place(300, 453); paddle_x = 10'd270;
        pix(300, 456); lit("pad_col", 2, 1); lit("pad_bot", 4, 1); lit("pad_top", 3, 0);

        place(86, 48);
        frame_pulse = 1'b1; pix(86, 48); frame_pulse = 1'b0;
        lit("fp_blank_bp", 0, 0); lit("fp_blank_col", 2, 0);

        ng();
        for (int r = 0; r < 6; r++) for (int c = 0; c < 8; c++) hit_brick(r, c);
        lit("clr_left", 8, 0); lit("clr_flag", 9, 1); lit("clr_score", 7, 48);
        ng();
        place(8, 48); pix(8, 48);
        ng(1'b1); lit("ngfp_left", 8, 48); lit("ngfp_score", 7, 0); lit("ngfp_clr", 9, 0);
        frame(); lit("ngfp_drop", 8, 48);

        for (int f = 0; f < 40; f++) begin
            if (f % 10 == 9) ng();
            paddle_x = 10'($urandom_range(0, 540));
            if (f % 4 == 3) place($urandom_range(0, 636), $urandom_range(448, 462));
            else            place($urandom_range(0, 636), $urandom_range(40, 150));
            for (int i = 0; i < 50; i++) begin
                int x, y;
                if ($urandom_range(0, 9) < 7) begin
                    x = int'(ball_x) + int'($urandom_range(0, 7)) - 2;
                    y = int'(ball_y) + int'($urandom_range(0, 7)) - 2;
                end else begin
                    x = $urandom_range(0, 639); y = $urandom_range(0, 479);
                end
                x = x < 0 ? 0 : (x > 639 ? 639 : x);
                y = y < 0 ? 0 : (y > 479 ? 479 : y);
                pix(x, y, $urandom_range(0, 9) != 0);
            end
            frame();
        end

        // Asynchronous reset in the middle of a frame with a hit pending.
        ng();
        hit_brick(0, 2); hit_brick(0, 3); hit_brick(0, 4);
        lit("pre_rst_score", 7, 3);
        place(8 + 5 * 78, 48); pix(8 + 5 * 78, 48); pix(20, 100);
        nRst = 1'b0;
        @(posedge clk); #2 nRst = 1'b1;
        lit("mrst_score", 7, 0); lit("mrst_left", 8, 48); lit("mrst_col", 2, 0); lit("mrst_bp", 0, 0);
        place(300, 300);
        pix(8 + 2 * 78, 48); lit("mrst_restored", 0, 1);
        frame(); lit("mrst_no_pend", 8, 48);

        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
